// File: rtl/core_mem.sv
// Byte-wide program/data memory for the stack-machine core: streams a program in, holds the core in reset until done, then decodes 0xFF-marker stores.
// Optional feature: define CORE_MEM_STORE_GUARD_EN to refuse arming on marker cycles at address 0.
module core_mem #(
  parameter int         DEPTH = 32,
  parameter logic [7:0] FILL  = 8'h0F
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] mem_addr,
  input  logic [7:0] core_data_out,
  output logic [7:0] core_data_in,
  output logic       core_reset,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic       ld_ready,
  output logic       wr_strobe
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_ARMED = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] ld_ptr_reg, ld_ptr_next;
  logic [7:0]    mem_reg [DEPTH];

  logic          addr_in_range;
  logic [AW-1:0] addr_idx;
  logic          arm_cond;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [7:0]    wr_data;

  assign addr_in_range = ({1'b0, mem_addr} < DEPTH_W);
  assign addr_idx      = mem_addr[AW-1:0];

`ifdef CORE_MEM_STORE_GUARD_EN
  // Halt/decode cycles sit at pc 0; a real store marker never does.
  assign arm_cond = (core_data_out == 8'hFF) && (mem_addr != 8'h00);
`else
  assign arm_cond = (core_data_out == 8'hFF);
`endif

  // Read path is combinational so the core sees data on the edge it drives the address.
  assign core_data_in = addr_in_range ? mem_reg[addr_idx] : FILL;

  assign core_reset = (state_reg == S_IDLE) || (state_reg == S_LOAD);
  // A restart pulse suppresses the transfer so the byte is not written at the stale pointer.
  assign ld_ready   = (state_reg == S_LOAD) && !ld_start;

  always_comb begin
    state_next  = state_reg;
    ld_ptr_next = ld_ptr_reg;
    wr_en       = 1'b0;
    wr_idx      = ld_ptr_reg;
    wr_data     = ld_data;
    wr_strobe   = 1'b0;
    if (ld_start) begin
      state_next  = S_LOAD;
      ld_ptr_next = '0;
    end else begin
      case (state_reg)
        S_LOAD: begin
          if (ld_valid) begin
            wr_en       = 1'b1;
            ld_ptr_next = ld_ptr_reg + 1'b1;
            if (ld_last || (ld_ptr_reg == AW'(DEPTH - 1)))
              state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (arm_cond)
            state_next = S_ARMED;
        end
        S_ARMED: begin
          state_next = S_RUN;
          if (addr_in_range) begin
            wr_en     = 1'b1;
            wr_idx    = addr_idx;
            wr_data   = core_data_out;
            wr_strobe = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      ld_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ld_ptr_reg <= ld_ptr_next;
    end
  end

  // Per-entry registers so an asynchronous reset restores FILL everywhere at once.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
          mem_reg[gi] <= FILL;
        else if (wr_en && (wr_idx == AW'(gi)))
          mem_reg[gi] <= wr_data;
      end
    end
  endgenerate

endmodule

// File: tb/tb_core_mem.sv
// Scoreboard bench for core_mem: stimulus queues expected values, a negedge monitor pops and compares.
module tb_core_mem;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] mem_addr;
  logic [7:0] core_data_out;
  logic [7:0] core_data_in;
  logic       core_reset;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       wr_strobe;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Level expectations: 0 = core_data_in, 1 = core_reset, 2 = ld_ready, 3 = wr_strobe
  string      exp_name [$];
  int         exp_sel  [$];
  logic [7:0] exp_val  [$];
  // Store expectations: address and data seen when wr_strobe pulses
  logic [7:0] st_addr  [$];
  logic [7:0] st_data  [$];

  core_mem #(.DEPTH(32), .FILL(8'h0F)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .mem_addr      (mem_addr),
    .core_data_out (core_data_out),
    .core_data_in  (core_data_in),
    .core_reset    (core_reset),
    .ld_start      (ld_start),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
    .ld_last       (ld_last),
    .ld_ready      (ld_ready),
    .wr_strobe     (wr_strobe)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_sig(input string name, input int sel, input logic [7:0] val);
    exp_name.push_back(name);
    exp_sel.push_back(sel);
    exp_val.push_back(val);
  endtask

  task automatic expect_store(input logic [7:0] a, input logic [7:0] d);
    st_addr.push_back(a);
    st_data.push_back(d);
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] val);
    mem_addr = a;
    expect_sig(name, 0, val);
    tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    expect_sig("load_ready", 2, 8'h01);
    expect_sig("load_core_reset", 1, 8'h01);
    tick();
  endtask

  // Monitor: compares everything queued for this cycle, plus any store strobe.
  always @(negedge clock) begin
    logic [7:0] act;
    string      n;
    int         s;
    logic [7:0] e;
    logic [7:0] ea, ed;
    while (exp_name.size() > 0) begin
      n = exp_name.pop_front();
      s = exp_sel.pop_front();
      e = exp_val.pop_front();
      case (s)
        0:       act = core_data_in;
        1:       act = {7'd0, core_reset};
        2:       act = {7'd0, ld_ready};
        default: act = {7'd0, wr_strobe};
      endcase
      total_cnt++;
      if (act === e) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", n, act, e);
    end
    if (wr_strobe === 1'b1) begin
      total_cnt++;
      if (st_addr.size() == 0) begin
        $display("FAIL unexpected_store: addr %h data %h", mem_addr, core_data_out);
      end else begin
        ea = st_addr.pop_front();
        ed = st_data.pop_front();
        if (mem_addr === ea && core_data_out === ed) pass_cnt++;
        else $display("FAIL store: got addr %h data %h, expected addr %h data %h",
                      mem_addr, core_data_out, ea, ed);
      end
    end
  end

  initial begin
    reset_n = 1'b0; mem_addr = 8'h00; core_data_out = 8'h00;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;

    // Reset state
    expect_sig("rst_core_reset", 1, 8'h01);
    expect_sig("rst_ld_ready", 2, 8'h00);
    expect_sig("rst_wr_strobe", 3, 8'h00);
    expect_sig("rst_read0", 0, 8'h0F);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Load three bytes, last flagged on the third
    ld_start = 1'b1;
    expect_sig("idle_ld_ready", 2, 8'h00);
    tick();
    ld_start = 1'b0;
    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h0E, 1'b1);
    ld_valid = 1'b0; ld_last = 1'b0;
    expect_sig("run_core_reset", 1, 8'h00);
    expect_sig("run_ld_ready", 2, 8'h00);
    read_check("rd0", 8'd0, 8'h08);
    read_check("rd1", 8'd1, 8'h05);
    read_check("rd2", 8'd2, 8'h0E);
    read_check("rd3", 8'd3, 8'h0F);
    read_check("rd31", 8'd31, 8'h0F);
    read_check("rd32", 8'd32, 8'h0F);
    read_check("rd200", 8'd200, 8'h0F);

    // Store 0x3C to 0x10
    core_data_out = 8'hFF; mem_addr = 8'h05;
    expect_sig("marker_no_strobe", 3, 8'h00);
    tick();
    core_data_out = 8'h3C; mem_addr = 8'h10;
    expect_sig("store_strobe", 3, 8'h01);
    expect_sig("store_read_old", 0, 8'h0F);
    expect_store(8'h10, 8'h3C);
    tick();
    core_data_out = 8'h00;
    expect_sig("after_store_strobe", 3, 8'h00);
    read_check("rd10", 8'h10, 8'h3C);

    // Store 0xFF to 0x11 must not re-arm
    core_data_out = 8'hFF; mem_addr = 8'h11;
    tick();
    expect_sig("ff_store_strobe", 3, 8'h01);
    expect_store(8'h11, 8'hFF);
    tick();
    core_data_out = 8'h00;
    expect_sig("ff_no_rearm", 3, 8'h00);
    read_check("rd11", 8'h11, 8'hFF);

    // Out-of-range store is dropped
    core_data_out = 8'hFF; mem_addr = 8'h05;
    tick();
    core_data_out = 8'h55; mem_addr = 8'h40;
    expect_sig("oor_no_strobe", 3, 8'h00);
    tick();
    core_data_out = 8'h00;
    expect_sig("oor_back_run", 3, 8'h00);
    expect_sig("oor_core_reset", 1, 8'h00);
    tick();

    // Halt aliasing at address 0
    core_data_out = 8'hFF; mem_addr = 8'h00;
    tick();
    core_data_out = 8'h77; mem_addr = 8'h00;
`ifdef CORE_MEM_STORE_GUARD_EN
    expect_sig("alias_no_strobe", 3, 8'h00);
    tick();
    core_data_out = 8'h00;
    read_check("alias_rd0", 8'h00, 8'h08);
`else
    expect_sig("alias_strobe", 3, 8'h01);
    expect_store(8'h00, 8'h77);
    tick();
    core_data_out = 8'h00;
    read_check("alias_rd0", 8'h00, 8'h77);
`endif

    // ld_start while ARMED discards the store
    core_data_out = 8'hFF; mem_addr = 8'h05;
    tick();
    ld_start = 1'b1; core_data_out = 8'h99; mem_addr = 8'h12;
    expect_sig("armed_restart_no_strobe", 3, 8'h00);
    tick();
    ld_start = 1'b0; core_data_out = 8'h00;
    expect_sig("restart_core_reset", 1, 8'h01);
    expect_sig("restart_ld_ready", 2, 8'h01);

    // Forty bytes without ld_last: only DEPTH are accepted
    for (int i = 0; i < 40; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'h80 + 8'(i);
      if (i == 0 || i == 31) expect_sig("full_ready", 2, 8'h01);
      if (i == 32 || i == 39) begin
        expect_sig("full_not_ready", 2, 8'h00);
        expect_sig("full_released", 1, 8'h00);
      end
      tick();
    end
    ld_valid = 1'b0;
    read_check("full_rd0", 8'h00, 8'h80);
    read_check("full_rd10", 8'h10, 8'h90);
    read_check("full_rd12", 8'h12, 8'h92);
    read_check("full_rd31", 8'd31, 8'h9F);

    // Asynchronous reset mid-load
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    ld_valid = 1'b1; ld_data = 8'h33; mem_addr = 8'h00;
    #2;
    reset_n = 1'b0;
    expect_sig("arst_ld_ready", 2, 8'h00);
    expect_sig("arst_core_reset", 1, 8'h01);
    expect_sig("arst_rd0", 0, 8'h0F);
    tick();
    ld_valid = 1'b0;
    reset_n = 1'b1;
    expect_sig("arst_idle_ready", 2, 8'h00);
    read_check("arst_rd1", 8'h01, 8'h0F);
    read_check("arst_rd31", 8'd31, 8'h0F);
    tick(); tick();

    total_cnt++;
    if (st_addr.size() == 0) pass_cnt++;
    else $display("FAIL missing_stores: got %0d outstanding, expected 0", st_addr.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/core_mem.md
Name: core_mem

Overview:
- Byte-wide program/data memory directly downstream of the stack-machine core.
- Consumes the core's mem_addr and data_out; produces the core's data_in.
- Owns core startup: holds the core in reset while a program is streamed in over a valid/ready byte port, then releases it.
- Decodes the core's store protocol: a 0xFF marker cycle, followed by a write-data cycle.

Parameters:
- DEPTH, 32, number of implemented bytes at addresses 0..DEPTH-1 (2..256).
- FILL, 8'h0F, value read from empty/unimplemented locations (OP_NUL encoding).

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- mem_addr  in  8  address from the core.
- core_data_out  in  8  core's data_out bus (store marker and store data).
- core_data_in  out  8  read data to the core's data_in.
- core_reset  out  1  synchronous active-high reset to the core.
- ld_start  in  1  single-cycle pulse: begin a (re)load.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_last  in  1  qualifies the final loader byte.
- ld_ready  out  1  loader may transfer.
- wr_strobe  out  1  one-cycle pulse on each committed core store.

Behaviour:
- Storage: DEPTH x 8 register array. Async reset fills every entry with FILL.
- Read path: combinational, zero latency. The core samples data_in on the same edge it drives mem_addr.
  - core_data_in = mem[mem_addr] if mem_addr < DEPTH, else FILL.
  - The read path is valid in every state.
- States: IDLE, LOAD, RUN, ARMED. Reset enters IDLE with ld_ptr = 0.
- Reset values: core_reset = 1, ld_ready = 0, wr_strobe = 0.
- IDLE:
  - core_reset = 1, ld_ready = 0.
  - ld_start -> LOAD with ld_ptr = 0.
- LOAD:
  - core_reset = 1, ld_ready = 1.
  - Transfer occurs when ld_valid & ld_ready: mem[ld_ptr] <= ld_data, then ld_ptr++.
  - Exit to RUN when the transfer carries ld_last, or when it writes address DEPTH-1 (buffer full). Later bytes are not accepted.
  - Untouched locations keep their previous contents.
  - ld_start in LOAD restarts at ld_ptr = 0.
- RUN:
  - core_reset = 0 from the first RUN cycle, so the core exits reset on the next edge.
  - If core_data_out == 8'hFF -> ARMED (marker).
- ARMED:
  - core_reset = 0.
  - On the edge: if mem_addr < DEPTH, mem[mem_addr] <= core_data_out and wr_strobe = 1 this cycle. Otherwise the write is dropped and wr_strobe = 0.
  - Always returns to RUN. A stored value of 0xFF does not re-arm.
- Write/read ordering: a read in the same cycle as a write returns the old value.
- ld_start in RUN or ARMED:
  - Any pending ARMED write is discarded.
  - Next state is LOAD, ld_ptr = 0, core_reset = 1 next cycle.
- ld_start has priority over all other transitions.
- Async reset mid-load or mid-store: the array returns to FILL and the state to IDLE immediately. No partial write survives.
- Known aliasing: the core's halt output also appears on data_out. A 0xFF halt value therefore arms a write of 0xFF to the address then on mem_addr (0). The optional feature below addresses this.

Optional Feature:
- Macro: CORE_MEM_STORE_GUARD_EN.
- Defined: RUN -> ARMED additionally requires mem_addr != 0 in the marker cycle. A genuine store marker always carries pc >= 1, so halt/decode marker cycles at address 0 never write.
- Not defined: arming depends on core_data_out alone, as above.

Test Plan:
- Load 0x08,0x05,0x0E with ld_last on byte 3:
  - ld_ready high 3 transfers; core_reset falls the cycle after the last transfer.
  - mem[0..2] = 08,05,0E; mem[3..31] = 0x0F.
- Reads at mem_addr = 2, 31, 32, 200 after load -> core_data_in = 0x0E, 0x0F, 0x0F, 0x0F the same cycle.
- In RUN: core_data_out = FF with mem_addr = 5, then 0x3C with mem_addr = 0x10 -> mem[0x10] = 0x3C, wr_strobe one cycle.
  - Then FF, FF at 0x11 -> mem[0x11] = FF with a single strobe; back in RUN with no second write.
- Store to mem_addr = 0x40 (>= DEPTH) -> no write, no strobe, state RUN.
- Load 40 bytes without ld_last -> exactly 32 accepted, ld_ready low afterwards, core released.
  - ld_start in ARMED -> no write, core_reset = 1, LOAD.
- core_data_out = FF at mem_addr = 0, then 0x77 at mem_addr = 0:
  - Without the macro, mem[0] = 0x77.
  - With CORE_MEM_STORE_GUARD_EN, mem[0] is unchanged and no strobe.
  - reset_n low mid-LOAD -> all entries 0x0F, state IDLE, ld_ready = 0 asynchronously.
